instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/if_id_reg.sv | 67 ++++++
 rtl/instr_fetch.sv | 100 ++++++++++
 tb/tb_instr_fetch.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and constants: state encoding, datapath widths, reset vector.
package riscv_pkg;

    localparam int XLEN  = 32;
    localparam int OPC_W = 7;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        SKID  = 2'd2,
        DROP  = 2'd3
    } fetch_state_e;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
        return a & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID output register plus one skid entry; a load appears on the outputs one cycle later.
// Backpressure: a load arriving while the output is held goes to skid; flush empties both.
module if_id_reg
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_flush,
    input  logic            i_load_vld,
    input  logic [XLEN-1:0] i_load_instr,
    input  logic [XLEN-1:0] i_load_pc,
    input  logic            i_id_ready,
    output logic            o_id_valid,
    output logic [XLEN-1:0] o_id_instr,
    output logic [XLEN-1:0] o_id_pc,
    output logic            o_slot_free
);

    logic            r_out_vld;
    logic [XLEN-1:0] r_out_instr;
    logic [XLEN-1:0] r_out_pc;
    logic            r_skid_vld;
    logic [XLEN-1:0] r_skid_instr;
    logic [XLEN-1:0] r_skid_pc;
    logic            w_slot_free;

    assign w_slot_free = !r_out_vld || i_id_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_vld    <= 1'b0;
            r_out_instr  <= '0;
            r_out_pc     <= '0;
            r_skid_vld   <= 1'b0;
            r_skid_instr <= '0;
            r_skid_pc    <= '0;
        end else if (i_flush) begin
            r_out_vld  <= 1'b0;
            r_skid_vld <= 1'b0;
        end else if (r_skid_vld) begin
            // Output stays valid: the skid word replaces the one just consumed.
            if (i_id_ready) begin
                r_out_instr <= r_skid_instr;
                r_out_pc    <= r_skid_pc;
                r_skid_vld  <= 1'b0;
            end
        end else if (i_load_vld) begin
            if (w_slot_free) begin
                r_out_vld   <= 1'b1;
                r_out_instr <= i_load_instr;
                r_out_pc    <= i_load_pc;
            end else begin
                r_skid_vld   <= 1'b1;
                r_skid_instr <= i_load_instr;
                r_skid_pc    <= i_load_pc;
            end
        end else if (i_id_ready) begin
            r_out_vld <= 1'b0;
        end
    end

    assign o_id_valid  = r_out_vld;
    assign o_id_instr  = r_out_instr;
    assign o_id_pc     = r_out_pc;
    assign o_slot_free = w_slot_free;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch with one outstanding request; zero-wait memory yields one word per 2 cycles.
// Backpressure: decode stall parks one word in skid and suspends requests; redirects flush.
module instr_fetch
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [XLEN-1:0]  imem_rdata,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    input  logic             id_ready,
    output logic             id_valid,
    output logic [XLEN-1:0]  id_instr,
    output logic [XLEN-1:0]  id_pc,
    output logic [OPC_W-1:0] id_opcode
);

    fetch_state_e    r_state;
    fetch_state_e    w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_nxt;
    logic            w_load;
    logic            w_flush;
    logic            w_slot_free;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FETCH;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_load      = 1'b0;
        w_flush     = 1'b0;
        if (redirect_valid) begin
            // A granted-but-unanswered request must still be drained in DROP.
            w_flush  = 1'b1;
            w_pc_nxt = align_word(redirect_pc);
            case (r_state)
                FETCH:   w_state_nxt = imem_gnt    ? DROP  : FETCH;
                WAIT:    w_state_nxt = imem_rvalid ? FETCH : DROP;
                SKID:    w_state_nxt = FETCH;
                DROP:    w_state_nxt = imem_rvalid ? FETCH : DROP;
                default: w_state_nxt = FETCH;
            endcase
        end else begin
            case (r_state)
                FETCH: begin
                    if (imem_gnt) w_state_nxt = WAIT;
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        w_load      = 1'b1;
                        w_pc_nxt    = r_pc + XLEN'(4);
                        w_state_nxt = w_slot_free ? FETCH : SKID;
                    end
                end
                SKID: begin
                    if (id_ready) w_state_nxt = FETCH;
                end
                DROP: begin
                    if (imem_rvalid) w_state_nxt = FETCH;
                end
                default: w_state_nxt = FETCH;
            endcase
        end
    end

    assign imem_req  = rst_n && (r_state == FETCH);
    assign imem_addr = r_pc;

    if_id_reg u_if_id_reg (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_flush      (w_flush),
        .i_load_vld   (w_load),
        .i_load_instr (imem_rdata),
        .i_load_pc    (r_pc),
        .i_id_ready   (id_ready),
        .o_id_valid   (id_valid),
        .o_id_instr   (id_instr),
        .o_id_pc      (id_pc),
        .o_slot_free  (w_slot_free)
    );

    assign id_opcode = id_instr[OPC_W-1:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: directed stimulus pushes expected words, a monitor pops on handshake.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [6:0]  id_opcode;

    logic        gnt_en = 1'b1;
    int          lat = 1;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_opcode      (id_opcode)
    );

    assign imem_gnt = imem_req & gnt_en;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [6:0]  opc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] instr, input logic [6:0] opc);
        exp_t e;
        e.pc = pc; e.instr = instr; e.opc = opc;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory model: word at address a is a + 0x13; response lat cycles after grant.
    logic        m_pend = 1'b0;
    logic [31:0] m_addr = 32'h0;
    int          m_cnt  = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_pend      = 1'b0;
            imem_rvalid = 1'b0;
            imem_rdata  = 32'h0;
        end else begin
            imem_rvalid = 1'b0;
            if (m_pend) begin
                if (m_cnt == 1) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = m_addr + 32'h13;
                    m_pend      = 1'b0;
                end else begin
                    m_cnt--;
                end
            end
            if (imem_req && imem_gnt) begin
                chk("single_outstanding", {31'b0, m_pend}, 32'h0);
                m_pend = 1'b1;
                m_addr = imem_addr;
                m_cnt  = lat;
            end
        end
    end

    // Monitor: a handshake seen here completes at the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && id_valid && id_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_output: got pc %h instr %h, required no output", id_pc, id_instr);
            end else begin
                e = exp_q.pop_front();
                chk("out_pc", id_pc, e.pc);
                chk("out_instr", id_instr, e.instr);
                chk("out_opcode", {25'b0, id_opcode}, {25'b0, e.opc});
            end
        end
    end

    initial begin
        #5000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        repeat (3) tick();
        chk("rst_id_valid", {31'b0, id_valid}, 32'h0);
        chk("rst_id_instr", id_instr, 32'h0);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_imem_req", {31'b0, imem_req}, 32'h0);

        rst_n = 1'b1;                                     // cycle 0
        #1;
        chk("c0_req", {31'b0, imem_req}, 32'h1);
        chk("c0_addr", imem_addr, 32'h0);
        push(32'h0, 32'h0000_0013, 7'h13);
        tick();                                           // cycle 1
        chk("c1_valid", {31'b0, id_valid}, 32'h0);
        chk("c1_req", {31'b0, imem_req}, 32'h0);
        tick();                                           // cycle 2
        chk("c2_valid", {31'b0, id_valid}, 32'h1);
        chk("c2_pc", id_pc, 32'h0);
        chk("c2_opcode", {25'b0, id_opcode}, 32'h13);
        id_ready = 1'b1;
        push(32'h4, 32'h0000_0017, 7'h17);
        tick();                                           // cycle 3
        chk("c3_valid_drop", {31'b0, id_valid}, 32'h0);
        tick();                                           // cycle 4
        chk("c4_pc", id_pc, 32'h4);
        id_ready = 1'b0;
        push(32'h8, 32'h0000_001B, 7'h1B);
        tick();                                           // cycle 5
        tick();                                           // cycle 6
        chk("skid_req_c6", {31'b0, imem_req}, 32'h0);
        chk("skid_valid_c6", {31'b0, id_valid}, 32'h1);
        chk("skid_pc_c6", id_pc, 32'h4);
        tick();                                           // cycle 7
        chk("skid_req_c7", {31'b0, imem_req}, 32'h0);
        chk("skid_pc_c7", id_pc, 32'h4);
        id_ready = 1'b1;
        tick();                                           // cycle 8
        chk("skid_out_pc", id_pc, 32'h8);
        push(32'hC, 32'h0000_001F, 7'h1F);
        tick();                                           // cycle 9
        tick();                                           // cycle 10
        lat = 3;
        tick();                                           // cycle 11
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
        tick();                                           // cycle 12
        redirect_valid = 1'b0; lat = 1;
        chk("drop_req_c12", {31'b0, imem_req}, 32'h0);
        chk("drop_valid_c12", {31'b0, id_valid}, 32'h0);
        tick();                                           // cycle 13
        chk("drop_req_c13", {31'b0, imem_req}, 32'h0);
        tick();                                           // cycle 14
        chk("redir_req", {31'b0, imem_req}, 32'h1);
        chk("redir_addr", imem_addr, 32'h0000_0100);
        push(32'h100, 32'h0000_0113, 7'h13);
        tick();                                           // cycle 15
        tick();                                           // cycle 16
        gnt_en = 1'b0;
        tick();                                           // cycle 17
        chk("ungnt_addr", imem_addr, 32'h0000_0104);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0203;
        tick();                                           // cycle 18
        redirect_valid = 1'b0;
        chk("align_req", {31'b0, imem_req}, 32'h1);
        chk("align_addr", imem_addr, 32'h0000_0200);
        gnt_en = 1'b1;
        push(32'h200, 32'h0000_0213, 7'h13);
        tick();                                           // cycle 19
        gnt_en = 1'b0;
        tick();                                           // cycle 20
        tick();                                           // cycle 21
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC; gnt_en = 1'b1;
        tick();                                           // cycle 22
        redirect_valid = 1'b0;
        chk("gnt_redir_drop_req", {31'b0, imem_req}, 32'h0);
        tick();                                           // cycle 23
        chk("top_addr", imem_addr, 32'hFFFF_FFFC);
        push(32'hFFFF_FFFC, 32'h0000_000F, 7'h0F);
        tick();                                           // cycle 24
        tick();                                           // cycle 25
        chk("wrap_req", {31'b0, imem_req}, 32'h1);
        chk("wrap_addr", imem_addr, 32'h0);
        push(32'h0, 32'h0000_0013, 7'h13);
        tick();                                           // cycle 26
        tick();                                           // cycle 27
        chk("pre_rst_valid", {31'b0, id_valid}, 32'h1);
        chk("pre_rst_pc", id_pc, 32'h0);
        lat = 3; id_ready = 1'b0;
        tick();                                           // cycle 28, WAIT
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'b0, id_valid}, 32'h0);
        chk("async_rst_instr", id_instr, 32'h0);
        chk("async_rst_req", {31'b0, imem_req}, 32'h0);
        exp_q.delete();
        tick();
        lat = 1;
        rst_n = 1'b1;
        #1;
        chk("post_rst_req", {31'b0, imem_req}, 32'h1);
        chk("post_rst_addr", imem_addr, 32'h0);
        chk("post_rst_valid", {31'b0, id_valid}, 32'h0);
        push(32'h0, 32'h0000_0013, 7'h13);
        id_ready = 1'b1;
        repeat (4) tick();
        chk("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
